// File: rtl/ff_d_asincrono.sv
// ff_d_asincrono: positive-edge D register with asynchronous active-low reset,
// complementary outputs, and an optional reset-release synchronizer.
//
// Reset assertion always clears the register and the synchronizer immediately.
// Reset release is made glitch-safe by a short shift chain. The data register
// stays at RST_VAL until a 1 has walked through every stage.
//
// Parameters:
//   WIDTH           : width of data/q/qbar (1 or more)
//   RST_VAL         : value held on q while in reset or while the chain fills
//   RST_SYNC_STAGES : synchronizer depth (0..4); 0 means no synchronizer
module ff_d_asincrono #(
  parameter int                WIDTH           = 1,
  parameter logic [WIDTH-1:0]  RST_VAL         = '0,
  parameter int                RST_SYNC_STAGES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic             w_runEnable;
  logic [WIDTH-1:0] r_q;

  generate
    if (RST_SYNC_STAGES > 0) begin : g_sync
      logic [RST_SYNC_STAGES-1:0] r_syncChain;

      // Shift chain cleared asynchronously by reset; a 1 enters stage 0 on
      // each edge while reset is released and ripples toward the last stage.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_syncChain <= '0;
        end else begin
          r_syncChain[0] <= 1'b1;
          for (int i = 1; i < RST_SYNC_STAGES; i++) begin
            r_syncChain[i] <= r_syncChain[i-1];
          end
        end
      end

      assign w_runEnable = r_syncChain[RST_SYNC_STAGES-1];
    end else begin : g_nosync
      assign w_runEnable = 1'b1;
    end
  endgenerate

  // Data register: asynchronous clear to RST_VAL; while the synchronizer is
  // still filling, RST_VAL is reloaded synchronously rather than via the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= RST_VAL;
    end else if (!w_runEnable) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= data;
    end
  end

  // Both outputs come from the single register, so they can never disagree.
  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

// File: tb/tb_ff_d_asincrono.sv
// tb_ff_d_asincrono: self-checking bench for ff_d_asincrono. Three instances
// run in parallel: default (1 bit, RST_VAL 0, no sync), 8 bits with RST_VAL
// 8'hA5, and 1 bit with a two-stage reset-release synchronizer.
module tb_ff_d_asincrono;

  localparam logic [7:0] RV8 = 8'hA5;
  localparam int         N2  = 2;

  logic       clk;
  logic       reset;
  logic       d1;
  logic [7:0] d8;
  logic       d2;
  logic       q1, qb1;
  logic [7:0] q8, qb8;
  logic       q2, qb2;

  logic       m1;
  logic [7:0] m8;
  logic       m2;
  int         fill2;

  int checks;
  int failures;

  ff_d_asincrono dutDefault (
    .clk  (clk),
    .reset(reset),
    .data (d1),
    .q    (q1),
    .qbar (qb1)
  );

  ff_d_asincrono #(.WIDTH(8), .RST_VAL(RV8), .RST_SYNC_STAGES(0)) dutWide (
    .clk  (clk),
    .reset(reset),
    .data (d8),
    .q    (q8),
    .qbar (qb8)
  );

  ff_d_asincrono #(.WIDTH(1), .RST_VAL(1'b0), .RST_SYNC_STAGES(N2)) dutSync (
    .clk  (clk),
    .reset(reset),
    .data (d2),
    .q    (q2),
    .qbar (qb2)
  );

  // 20 ns clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, " q1"},   {7'b0, q1},  {7'b0, m1});
    cmp({tag, " qb1"},  {7'b0, qb1}, {7'b0, ~m1});
    cmp({tag, " q8"},   q8,          m8);
    cmp({tag, " qb8"},  qb8,         ~m8);
    cmp({tag, " q2"},   {7'b0, q2},  {7'b0, m2});
    cmp({tag, " qb2"},  {7'b0, qb2}, {7'b0, ~m2});
  endtask

  // Reference: reset forces reset values and empties the sync count
  task automatic modelResetAssert();
    m1    = 1'b0;
    m8    = RV8;
    m2    = 1'b0;
    fill2 = 0;
  endtask

  // Reference behaviour at a rising edge
  task automatic modelEdge();
    if (!reset) begin
      modelResetAssert();
    end else begin
      m1 = d1;
      m8 = d8;
      if (fill2 >= N2) begin
        m2 = d2;
      end else begin
        fill2++;
        m2 = 1'b0;
      end
    end
  endtask

  // Drive reset/data at the falling edge, clock once, check just after
  task automatic applyStimulus(input logic rst, input logic a1, input logic [7:0] a8,
                               input logic a2, input string tag);
    @(negedge clk);
    reset = rst;
    d1    = a1;
    d8    = a8;
    d2    = a2;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    d1       = 1'b0;
    d8       = 8'h3C;
    d2       = 1'b0;
    m1       = 1'b0;
    m8       = RV8;
    m2       = 1'b0;
    fill2    = 0;

    // Power-up reset, asynchronous before any clock edge
    #2;
    reset = 1'b0;
    modelResetAssert();
    #1;
    checkOutput("powerup");

    // Clock running with reset low, data 0 then 1
    applyStimulus(1'b0, 1'b0, 8'h3C, 1'b0, "rstHold0");
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, "rstHold1");

    // Release: wide captures 3C, default captures 1, sync holds two edges
    applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1, "release1");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, "release2");
    applyStimulus(1'b1, 1'b1, 8'h81, 1'b1, "release3");

    // Randomized capture
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), "rand");
    end

    // Force q=1 then assert reset 5 ns after an edge
    applyStimulus(1'b1, 1'b1, 8'h7E, 1'b1, "preAsync");
    #4;
    reset = 1'b0;
    modelResetAssert();
    #1;
    checkOutput("asyncAssert");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, "asyncHold");
    end

    // Release again; sync instance must refill from empty
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b1, "refill");
    end

    // Data toggling entirely between edges has no effect
    applyStimulus(1'b1, 1'b0, 8'h12, 1'b0, "preHold");
    #3;  d1 = 1'b1; d8 = 8'hED; d2 = 1'b1;
    #3;  d1 = 1'b0; d8 = 8'h12; d2 = 1'b0;
    #3;  d1 = 1'b1; d8 = 8'hED; d2 = 1'b1;
    #3;
    checkOutput("holdBetween");

    // More random traffic
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), "rand2");
    end

    // Reset asserted right on a rising edge: reset wins
    applyStimulus(1'b1, 1'b1, 8'h5F, 1'b1, "preCoincide");
    @(negedge clk);
    d1 = 1'b1;
    d8 = 8'hC3;
    d2 = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    modelResetAssert();
    #1;
    checkOutput("coincide");
    applyStimulus(1'b0, 1'b1, 8'hC3, 1'b1, "coincideHold");

    $display("[TB] directed and random sequence complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
